// File: rtl/mac_pkg.sv
// Shared types and helpers for the serial-multiplier datapath stages.
// Holds the deserializer FSM encoding and its counter-width rule.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SKIP,
    COLLECT
  } deser_state_t;

  function automatic int cnt_w(input int p, input int lat);
    return $clog2(p + lat);
  endfunction

endpackage

// File: rtl/prod_buf2.sv
// Two-entry in-order valid/ready buffer; the head entry drives dout.
// A push is accepted when not full, or when full and popping in the same edge.
module prod_buf2 #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  output logic         full,
  output logic [W-1:0] dout,
  output logic         vld,
  input  logic         rdy
);

  logic [W-1:0] mem_q [2];
  logic [1:0]   cnt_q;
  logic [1:0]   cnt_d;
  logic [1:0]   fill;
  logic         pop;
  logic         do_push;

  assign vld     = (cnt_q != 2'd0);
  assign full    = (cnt_q == 2'd2);
  assign dout    = mem_q[0];
  assign pop     = vld && rdy;
  assign do_push = push && (!full || pop);
  // Slot the new word lands in, after the head shift of a simultaneous pop.
  assign fill    = cnt_q - {1'b0, pop};
  assign cnt_d   = cnt_q + {1'b0, do_push} - {1'b0, pop};

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= 2'd0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      if (pop) begin
        mem_q[0] <= mem_q[1];
      end
      if (do_push) begin
        if (fill == 2'd0) begin
          mem_q[0] <= din;
        end else begin
          mem_q[1] <= din;
        end
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mult_seq_deser.sv
// Captures the LSB-first serial product of the bit-serial multiplier into a
// P-bit word and hands it to a consumer through a 2-entry buffer.
module mult_seq_deser
  import mac_pkg::*;
#(
  parameter int N   = 1024,
  parameter int M   = N,
  parameter int LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           aX,
  output logic [N+M-1:0] prod,
  output logic           prod_vld,
  input  logic           prod_rdy,
  output logic           busy,
  output logic           start_err,
  output logic           ovf
);

  localparam int P  = N + M;
  localparam int CW = cnt_w(P, LAT);
  localparam logic [CW-1:0] LAST_CNT  = CW'(P - 1);
  // SKIP exits one edge after reaching zero, so preload LAT-2 to land bit 0 on E0+LAT.
  localparam logic [CW-1:0] SKIP_INIT = CW'((LAT >= 2) ? (LAT - 2) : 0);

  deser_state_t  state_q;
  logic [CW-1:0] cnt_q;
  logic [P-1:0]  shreg_q;
  logic [P-1:0]  shreg_d;
  logic          start_err_q;
  logic          ovf_q;

  logic          last_bit;
  logic          push;
  logic          pop;
  logic          buf_full;

  assign last_bit  = (state_q == COLLECT) && (cnt_q == LAST_CNT);
  assign push      = last_bit;
  assign pop       = prod_vld && prod_rdy;
  assign busy      = (state_q != IDLE);
  assign start_err = start_err_q;
  assign ovf       = ovf_q;

  always_comb begin
    shreg_d = shreg_q;
    if (state_q == COLLECT) begin
      shreg_d[cnt_q] = aX;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      start_err_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      start_err_q <= 1'b0;
      shreg_q     <= shreg_d;
      if (push && buf_full && !pop) begin
        ovf_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            cnt_q <= (LAT == 1) ? '0 : SKIP_INIT;
            state_q <= (LAT == 1) ? COLLECT : SKIP;
          end
        end
        SKIP: begin
          if (start) begin
            start_err_q <= 1'b1;
          end
          if (cnt_q == '0) begin
            state_q <= COLLECT;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        COLLECT: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST_CNT) begin
            // A start on the completing edge opens the next frame immediately.
            if (start) begin
              cnt_q   <= (LAT == 1) ? '0 : SKIP_INIT;
              state_q <= (LAT == 1) ? COLLECT : SKIP;
            end else begin
              state_q <= IDLE;
            end
          end else if (start) begin
            start_err_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  prod_buf2 #(
    .W(P)
  ) u_buf (
    .clk (clk),
    .rst (rst),
    .push(push),
    .din (shreg_d),
    .full(buf_full),
    .dout(prod),
    .vld (prod_vld),
    .rdy (prod_rdy)
  );

endmodule
